phase_sequencer: RTL and testbench

Parametrised traffic-intersection controller that sequences `NUM_PHASES` conflicting phases through GREEN, YELLOW and ALL-RED with per-phase green durations. It provides sensor-actuated skipping and latched pedestrian requests, with an integrated seconds timer. It is the next-generation replacement for the fixed three-approach controller-plus-timer pair. It sits between the sensor/button GPIOs and the per-lamp `semaforo`/`semaforo2` drivers, clocked from the 10 kHz low-frequency oscillator.

---
 rtl/traffic_pkg.sv | 26 ++
 rtl/second_timer.sv | 65 ++++++
 rtl/phase_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_phase_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg
//  Description : Shared definitions for the phase sequencer family: 2-bit
//                lamp codes, the controller state enumeration and the width
//                of one lamp code.
//  Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    localparam int LIGHT_W = 2;

    localparam logic [LIGHT_W-1:0] c_RED    = 2'b00;
    localparam logic [LIGHT_W-1:0] c_YELLOW = 2'b01;
    localparam logic [LIGHT_W-1:0] c_GREEN  = 2'b10;
    localparam logic [LIGHT_W-1:0] c_OFF    = 2'b11;

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_FLASH  = 2'd3
    } state_t;

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/second_timer.sv
`default_nettype none
// ============================================================================
//  Module      : second_timer
//  Description : Seconds prescaler plus duration down-counter. A load restarts
//                the prescaler at 0 and sets the counter to max(duration,1)-1.
//                sec_tick marks the last cycle of every second; finished marks
//                the tick on which the counter is already 0 (state expiry).
//  Ports       : clk, reset (async, active-high), load, duration[TIME_W]
//                -> sec_tick, finished
//  Revision    : 1.0 - initial release
// ============================================================================
module second_timer #(
    parameter int CLK_HZ = 10000,
    parameter int TIME_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [TIME_W-1:0] duration,
    output logic              sec_tick,
    output logic              finished
);

    localparam int PS_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PS_W-1:0] c_PS_LAST = PS_W'(CLK_HZ - 1);

    logic [PS_W-1:0]   r_prescale;
    logic [TIME_W-1:0] r_count;
    logic              r_fresh;
    logic [TIME_W-1:0] w_load_val;
    logic [TIME_W-1:0] w_count;

    // A zero duration behaves as one second.
    assign w_load_val = (duration == '0) ? '0 : duration - TIME_W'(1);

    // Straight after reset the counter has not captured a duration yet; the
    // live duration input stands in for it until the first clock edge.
    assign w_count  = r_fresh ? w_load_val : r_count;

    assign sec_tick = (r_prescale == c_PS_LAST);
    assign finished = sec_tick && (w_count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prescale <= '0;
            r_count    <= '0;
            r_fresh    <= 1'b1;
        end else if (load) begin
            r_prescale <= '0;
            r_count    <= w_load_val;
            r_fresh    <= 1'b0;
        end else begin
            r_fresh <= 1'b0;
            if (sec_tick) begin
                r_prescale <= '0;
                r_count    <= (w_count == '0) ? w_count : w_count - TIME_W'(1);
            end else begin
                r_prescale <= r_prescale + PS_W'(1);
                r_count    <= w_count;
            end
        end
    end

endmodule : second_timer
`default_nettype wire

// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : phase_sequencer
//  Description : Intersection controller sequencing NUM_PHASES conflicting
//                phases through GREEN -> YELLOW -> ALLRED, with round-robin
//                service of latched vehicle/pedestrian demand, recall to
//                phase 0 when idle, and a flashing-yellow mode when disabled.
//  Ports       : clk, reset (async, active-high), enable,
//                sensor[N], ped_req[N], green_time[N*TIME_W],
//                yellow_time[TIME_W], allred_time[TIME_W]
//                -> veh_light[2N], ped_light[2N], active_phase, sec_tick
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_sequencer #(
    parameter int NUM_PHASES = 4,
    parameter int CLK_HZ     = 10000,
    parameter int TIME_W     = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [NUM_PHASES-1:0]          sensor,
    input  logic [NUM_PHASES-1:0]          ped_req,
    input  logic [NUM_PHASES*TIME_W-1:0]   green_time,
    input  logic [TIME_W-1:0]              yellow_time,
    input  logic [TIME_W-1:0]              allred_time,
    output logic [2*NUM_PHASES-1:0]        veh_light,
    output logic [2*NUM_PHASES-1:0]        ped_light,
    output logic [$clog2(NUM_PHASES)-1:0]  active_phase,
    output logic                           sec_tick
);

    import traffic_pkg::*;

    localparam int PH_W = $clog2(NUM_PHASES);

    state_t                      r_state;
    state_t                      w_next_state;
    logic [PH_W-1:0]             r_phase;
    logic [PH_W-1:0]             w_next_phase;
    logic                        r_ped_on;
    logic                        w_next_ped_on;
    logic                        r_flash_on;
    logic                        w_next_flash_on;
    logic [NUM_PHASES-1:0]       r_veh_dem;
    logic [NUM_PHASES-1:0]       r_ped_dem;
    logic [NUM_PHASES-1:0]       w_dem;
    logic [NUM_PHASES-1:0]       w_clr;
    logic [PH_W-1:0]             w_sel;
    logic                        w_enter_green;
    logic                        w_load;
    logic                        w_finished;
    logic [TIME_W-1:0]           w_duration;
    logic [TIME_W-1:0]           w_green_sel;
    logic [2*NUM_PHASES-1:0]     r_veh_light;
    logic [2*NUM_PHASES-1:0]     r_ped_light;
    logic [2*NUM_PHASES-1:0]     w_veh_next;
    logic [2*NUM_PHASES-1:0]     w_ped_next;

    // ------------------------------------------------------------------
    // Seconds timer
    // ------------------------------------------------------------------
    second_timer #(
        .CLK_HZ (CLK_HZ),
        .TIME_W (TIME_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .duration (w_duration),
        .sec_tick (sec_tick),
        .finished (w_finished)
    );

    // ------------------------------------------------------------------
    // Round-robin arbiter: first demanding phase after the last served one,
    // wrapping, with the last served phase itself checked last. No demand
    // falls back to phase 0.
    // ------------------------------------------------------------------
    assign w_dem = r_veh_dem | r_ped_dem;

    always_comb begin : p_arbiter
        int   w_idx;
        logic w_found;
        w_sel   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= NUM_PHASES; k++) begin
            w_idx = int'(r_phase) + k;
            if (w_idx >= NUM_PHASES) begin
                w_idx = w_idx - NUM_PHASES;
            end
            if (!w_found && w_dem[PH_W'(w_idx)]) begin
                w_sel   = PH_W'(w_idx);
                w_found = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin : p_next_state
        w_next_state    = r_state;
        w_next_phase    = r_phase;
        w_next_ped_on   = r_ped_on;
        w_next_flash_on = r_flash_on;
        w_enter_green   = 1'b0;
        case (r_state)
            ST_ALLRED: begin
                if (w_finished) begin
                    if (!enable) begin
                        w_next_state    = ST_FLASH;
                        w_next_flash_on = 1'b1;
                    end else begin
                        w_next_state  = ST_GREEN;
                        w_next_phase  = w_sel;
                        w_next_ped_on = r_ped_dem[w_sel];
                        w_enter_green = 1'b1;
                    end
                end
            end
            ST_GREEN: begin
                if (w_finished) begin
                    w_next_state  = ST_YELLOW;
                    w_next_ped_on = 1'b0;
                end
            end
            ST_YELLOW: begin
                if (w_finished) begin
                    w_next_state = ST_ALLRED;
                end
            end
            ST_FLASH: begin
                if (enable) begin
                    w_next_state = ST_ALLRED;
                end else if (w_finished) begin
                    w_next_flash_on = ~r_flash_on;
                end
            end
            default: begin
                w_next_state = ST_ALLRED;
            end
        endcase
    end

    // Any state change, and every expiry (flash re-arms each second),
    // restarts the timer with the duration of the state being entered.
    assign w_load = (w_next_state != r_state) || w_finished;

    always_comb begin : p_green_sel
        w_green_sel = green_time[TIME_W-1:0];
        for (int p = 0; p < NUM_PHASES; p++) begin
            if (PH_W'(p) == w_next_phase) begin
                w_green_sel = green_time[p*TIME_W +: TIME_W];
            end
        end
    end

    always_comb begin : p_duration
        w_duration = allred_time;
        case (w_next_state)
            ST_ALLRED: w_duration = allred_time;
            ST_GREEN:  w_duration = w_green_sel;
            ST_YELLOW: w_duration = yellow_time;
            ST_FLASH:  w_duration = TIME_W'(1);
            default:   w_duration = allred_time;
        endcase
    end

    // ------------------------------------------------------------------
    // Demand latches: clearing on green entry overrides a same-cycle set
    // ------------------------------------------------------------------
    always_comb begin : p_clear
        w_clr = '0;
        for (int p = 0; p < NUM_PHASES; p++) begin
            w_clr[p] = w_enter_green && (PH_W'(p) == w_sel);
        end
    end

    // ------------------------------------------------------------------
    // Output decode from the next state so the lamp registers line up with
    // the state register.
    // ------------------------------------------------------------------
    always_comb begin : p_decode
        w_veh_next = {NUM_PHASES{c_RED}};
        w_ped_next = {NUM_PHASES{c_RED}};
        for (int p = 0; p < NUM_PHASES; p++) begin
            case (w_next_state)
                ST_GREEN: begin
                    if (PH_W'(p) == w_next_phase) begin
                        w_veh_next[p*LIGHT_W +: LIGHT_W] = c_GREEN;
                        if (w_next_ped_on) begin
                            w_ped_next[p*LIGHT_W +: LIGHT_W] = c_GREEN;
                        end
                    end
                end
                ST_YELLOW: begin
                    if (PH_W'(p) == w_next_phase) begin
                        w_veh_next[p*LIGHT_W +: LIGHT_W] = c_YELLOW;
                    end
                end
                ST_FLASH: begin
                    w_veh_next[p*LIGHT_W +: LIGHT_W] = w_next_flash_on ? c_YELLOW : c_OFF;
                end
                default: begin
                    w_veh_next[p*LIGHT_W +: LIGHT_W] = c_RED;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State, demand and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_ALLRED;
            r_phase     <= '0;
            r_ped_on    <= 1'b0;
            r_flash_on  <= 1'b0;
            r_veh_dem   <= '0;
            r_ped_dem   <= '0;
            r_veh_light <= {NUM_PHASES{c_RED}};
            r_ped_light <= {NUM_PHASES{c_RED}};
        end else begin
            r_state     <= w_next_state;
            r_phase     <= w_next_phase;
            r_ped_on    <= w_next_ped_on;
            r_flash_on  <= w_next_flash_on;
            r_veh_dem   <= (r_veh_dem | sensor)  & ~w_clr;
            r_ped_dem   <= (r_ped_dem | ped_req) & ~w_clr;
            r_veh_light <= w_veh_next;
            r_ped_light <= w_ped_next;
        end
    end

    assign veh_light    = r_veh_light;
    assign ped_light    = r_ped_light;
    assign active_phase = r_phase;

endmodule : phase_sequencer
`default_nettype wire

// File: tb/tb_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phase_sequencer
//  Description : Self-checking bench for phase_sequencer. A cycle-count model
//                predicts every output each cycle; directed scenarios pin the
//                model with hand-computed lamp patterns; randomized demand,
//                enable and duration traffic follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_sequencer;

    localparam int NP = 4;
    localparam int HZ = 4;
    localparam int TW = 8;

    // model modes
    localparam int M_ALLRED = 0;
    localparam int M_GREEN  = 1;
    localparam int M_YELLOW = 2;
    localparam int M_FLASH  = 3;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               enable = 1'b1;
    logic [NP-1:0]      sensor = '0;
    logic [NP-1:0]      ped_req = '0;
    logic [NP*TW-1:0]   green_time = {NP{8'd3}};
    logic [TW-1:0]      yellow_time = 8'd2;
    logic [TW-1:0]      allred_time = 8'd1;
    logic [2*NP-1:0]    veh_light;
    logic [2*NP-1:0]    ped_light;
    logic [1:0]         active_phase;
    logic               sec_tick;

    int n_tests = 0;
    int n_fail  = 0;

    phase_sequencer #(
        .NUM_PHASES (NP),
        .CLK_HZ     (HZ),
        .TIME_W     (TW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sensor       (sensor),
        .ped_req      (ped_req),
        .green_time   (green_time),
        .yellow_time  (yellow_time),
        .allred_time  (allred_time),
        .veh_light    (veh_light),
        .ped_light    (ped_light),
        .active_phase (active_phase),
        .sec_tick     (sec_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: elapsed cycles in the current interval against
    // its length in cycles (seconds * HZ).
    // ------------------------------------------------------------------
    int m_mode, m_e, m_len, m_phase;
    bit m_vdem[NP];
    bit m_pdem[NP];
    bit m_ped_on, m_flash_yel;

    function automatic int secs(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic void m_enter(input int mode, input int s);
        m_mode = mode;
        m_e    = 0;
        m_len  = s * HZ;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_enter(M_ALLRED, secs(int'(allred_time)));
            m_phase = 0; m_ped_on = 0; m_flash_yel = 0;
            for (int p = 0; p < NP; p++) begin
                m_vdem[p] = 0; m_pdem[p] = 0;
            end
        end else begin
            bit expire, found;
            int sel, cleared, idx;
            expire  = (m_e == m_len - 1);
            cleared = -1;
            sel     = 0;
            found   = 0;
            case (m_mode)
                M_ALLRED: begin
                    if (!expire) m_e++;
                    else if (!enable) begin
                        m_flash_yel = 1;
                        m_enter(M_FLASH, 1);
                    end else begin
                        for (int k = 1; k <= NP; k++) begin
                            idx = (m_phase + k) % NP;
                            if (!found && (m_vdem[idx] || m_pdem[idx])) begin
                                sel = idx; found = 1;
                            end
                        end
                        m_phase  = sel;
                        m_ped_on = m_pdem[sel];
                        cleared  = sel;
                        m_enter(M_GREEN, secs(int'(green_time[sel*TW +: TW])));
                    end
                end
                M_GREEN: begin
                    if (!expire) m_e++;
                    else begin
                        m_ped_on = 0;
                        m_enter(M_YELLOW, secs(int'(yellow_time)));
                    end
                end
                M_YELLOW: begin
                    if (!expire) m_e++;
                    else m_enter(M_ALLRED, secs(int'(allred_time)));
                end
                default: begin
                    if (enable) m_enter(M_ALLRED, secs(int'(allred_time)));
                    else if (expire) begin
                        m_flash_yel = !m_flash_yel;
                        m_e = 0;
                    end else m_e++;
                end
            endcase
            for (int p = 0; p < NP; p++) begin
                if (p == cleared) begin
                    m_vdem[p] = 0; m_pdem[p] = 0;
                end else begin
                    m_vdem[p] = m_vdem[p] | sensor[p];
                    m_pdem[p] = m_pdem[p] | ped_req[p];
                end
            end
        end
    end

    function automatic logic [2*NP-1:0] exp_veh();
        logic [2*NP-1:0] v;
        v = '0;
        for (int p = 0; p < NP; p++) begin
            if (m_mode == M_FLASH)                      v[2*p +: 2] = m_flash_yel ? 2'b01 : 2'b11;
            else if (m_mode == M_GREEN  && p == m_phase) v[2*p +: 2] = 2'b10;
            else if (m_mode == M_YELLOW && p == m_phase) v[2*p +: 2] = 2'b01;
        end
        return v;
    endfunction

    function automatic logic [2*NP-1:0] exp_ped();
        logic [2*NP-1:0] v;
        v = '0;
        if (m_mode == M_GREEN && m_ped_on) v[2*m_phase +: 2] = 2'b10;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Per-cycle comparison, away from the active edge
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        int lit;
        check("veh_light", 32'(veh_light), 32'(exp_veh()));
        check("ped_light", 32'(ped_light), 32'(exp_ped()));
        check("active_phase", 32'(active_phase), 32'(m_phase));
        check("sec_tick", 32'(sec_tick), 32'(((m_e % HZ) == HZ - 1) ? 1 : 0));
        lit = 0;
        for (int p = 0; p < NP; p++) if (veh_light[2*p +: 2] != 2'b00) lit++;
        if (veh_light != 8'h55 && veh_light != 8'hFF) check("one_phase_lit", 32'(lit > 1), 32'd0);
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    function automatic int green_idx();
        for (int p = 0; p < NP; p++) if (veh_light[2*p +: 2] == 2'b10) return p;
        return -1;
    endfunction

    task automatic wait_green(output int ph);
        bit prev, done;
        prev = (green_idx() >= 0);
        done = 0;
        ph   = -1;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (green_idx() >= 0 && !prev) begin
                ph = green_idx(); done = 1;
            end
            prev = (green_idx() >= 0);
        end
        if (!done) check("wait_green_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_veh(input logic [2*NP-1:0] val);
        bit done;
        done = 0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (veh_light == val) done = 1;
        end
        if (!done) check("wait_veh_timeout", 32'd1, 32'd0);
    endtask

    task automatic reset_sequence();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_veh", 32'(veh_light), 32'd0);
        check("reset_ped", 32'(ped_light), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("first_allred", 32'(veh_light), 32'd0);
        @(negedge clk);
        check("recall_green0", 32'(veh_light), 32'h02);
        check("recall_phase0", 32'(active_phase), 32'd0);
        repeat (11) @(negedge clk);
        check("green_12th", 32'(veh_light), 32'h02);
        @(negedge clk);
        check("yellow_entry", 32'(veh_light), 32'h01);
        repeat (7) @(negedge clk);
        check("yellow_8th", 32'(veh_light), 32'h01);
        @(negedge clk);
        check("allred_entry", 32'(veh_light), 32'h00);
        repeat (3) @(negedge clk);
        check("allred_4th", 32'(veh_light), 32'h00);
        @(negedge clk);
        check("recall_again", 32'(veh_light), 32'h02);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int ph, n;
        logic [2*NP-1:0] v;

        reset_sequence();

        // vehicle demand on phases 1 and 3 during phase 0 green
        sensor = 4'b1010;
        @(negedge clk);
        sensor = 4'b0000;
        wait_green(ph); check("rr_first", 32'(ph), 32'd1);
        wait_green(ph); check("rr_second", 32'(ph), 32'd3);
        wait_green(ph); check("rr_recall", 32'(ph), 32'd0);

        // pedestrian request on phase 2 during all-red
        wait_veh(8'h00);
        ped_req = 4'b0100;
        @(negedge clk);
        ped_req = 4'b0000;
        wait_green(ph); check("ped_phase", 32'(ph), 32'd2);
        check("ped_green_entry", 32'(ped_light), 32'h20);
        repeat (11) @(negedge clk);
        check("ped_green_12th", 32'(ped_light), 32'h20);
        @(negedge clk);
        check("ped_yellow_veh", 32'(veh_light), 32'h10);
        check("ped_yellow_ped", 32'(ped_light), 32'h00);

        // disable during green: clearance completes, then flash
        wait_green(ph);
        enable = 1'b0;
        wait_veh(8'h55);
        repeat (3) @(negedge clk);
        check("flash_yel_4th", 32'(veh_light), 32'h55);
        @(negedge clk);
        check("flash_off", 32'(veh_light), 32'hFF);
        repeat (3) @(negedge clk);
        check("flash_off_4th", 32'(veh_light), 32'hFF);
        @(negedge clk);
        check("flash_yel_again", 32'(veh_light), 32'h55);
        enable = 1'b1;
        @(negedge clk);
        check("flash_exit_allred", 32'(veh_light), 32'h00);
        repeat (3) @(negedge clk);
        check("flash_allred_4th", 32'(veh_light), 32'h00);
        @(negedge clk);
        check("flash_exit_green", 32'(veh_light), 32'h02);

        // zero green duration behaves as one second
        green_time[7:0] = 8'd0;
        wait_green(ph);
        check("zero_green_phase", 32'(ph), 32'd0);
        n = 1;
        for (int k = 0; k < 50 && veh_light == 8'h02; k++) begin
            @(negedge clk);
            if (veh_light == 8'h02) n++;
        end
        check("zero_green_len", 32'(n), 32'd4);
        green_time = {NP{8'd3}};

        // randomized demand, enable and durations
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            sensor  = ($urandom_range(0, 7) == 0) ? NP'($urandom) : '0;
            ped_req = ($urandom_range(0, 11) == 0) ? NP'($urandom) : '0;
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            if ($urandom_range(0, 149) == 0) begin
                for (int p = 0; p < NP; p++) green_time[p*TW +: TW] = TW'($urandom_range(0, 3));
                yellow_time = TW'($urandom_range(0, 3));
                allred_time = TW'($urandom_range(0, 3));
            end
        end
        sensor = '0; ped_req = '0; enable = 1'b1;
        green_time = {NP{8'd3}}; yellow_time = 8'd2; allred_time = 8'd1;

        // asynchronous reset in the middle of a yellow
        n = 0;
        for (int k = 0; k < 300 && n == 0; k++) begin
            @(negedge clk);
            v = veh_light;
            if (v != 8'h55 && v != 8'hFF && (v & 8'h55) != 0) n = 1;
        end
        check("found_yellow", 32'(n), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_veh", 32'(veh_light), 32'd0);
        check("async_reset_ped", 32'(ped_light), 32'd0);
        reset_sequence();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_phase_sequencer
`default_nettype wire
